// File: rtl/snake_game_ctrl_if.sv
// rtl/snake_game_ctrl_if.sv - signal bundle between the snake game sequencer and its neighbours
interface snake_game_ctrl_if #(
   parameter int SCORE_W = 7
);
   logic               start_i;
   logic               pause_i;
   logic [3:0]         dir_req_i;
   logic               good_coll_i;
   logic               bad_coll_i;
   logic [SCORE_W-1:0] score_i;
   logic               move_tick_o;
   logic [3:0]         dir_o;
   logic               good_coll_o;
   logic               bad_coll_o;
   logic [1:0]         state_o;
   logic               game_over_o;

   // pulse sources and score tracker side: drive requests, observe sequencer outputs
   modport master (
      output start_i, pause_i, dir_req_i, good_coll_i, bad_coll_i, score_i,
      input  move_tick_o, dir_o, good_coll_o, bad_coll_o, state_o, game_over_o
   );

   // sequencer side
   modport slave (
      input  start_i, pause_i, dir_req_i, good_coll_i, bad_coll_i, score_i,
      output move_tick_o, dir_o, good_coll_o, bad_coll_o, state_o, game_over_o
   );
endinterface

// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - game state machine, move tick, direction arbitration and collision gating
module snake_game_ctrl #(
   parameter int TICK_DIV  = 25,
   parameter int MAX_SCORE = 50,
   parameter int SCORE_W   = 7
) (
   input  logic              clk,
   input  logic              rst,
   snake_game_ctrl_if.slave  bus
);
   localparam int         CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [3:0] DIR_RIGHT = 4'b0001;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PLAYING = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_OVER    = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_pending;
   logic [3:0]       r_dir;
   logic             r_tick;
   logic             r_good;
   logic             r_bad;
   logic             r_over;

   logic             w_score_max;
   logic             w_onehot;
   logic [3:0]       w_dir_opp;
   logic             w_dir_valid;
   logic             w_wrap;
   logic             w_restart;
   logic             w_stay_play;

   assign w_score_max = {{(32-SCORE_W){1'b0}}, bus.score_i} >= MAX_SCORE;

   // A request must be one-hot and neither a reversal nor a repeat of the committed heading
   assign w_onehot    = (bus.dir_req_i != 4'd0) && ((bus.dir_req_i & (bus.dir_req_i - 4'd1)) == 4'd0);
   assign w_dir_opp   = {r_dir[2], r_dir[3], r_dir[0], r_dir[1]};
   assign w_dir_valid = w_onehot && (bus.dir_req_i != w_dir_opp) && (bus.dir_req_i != r_dir);

   assign w_wrap      = (r_cnt == CNT_W'(TICK_DIV - 1));
   assign w_restart   = ((r_state == ST_IDLE) || (r_state == ST_OVER)) && bus.start_i;
   // Ticks and counter progress only happen on cycles that stay in PLAYING,
   // which both freezes the counter on pause and drops a tick scheduled on exit
   assign w_stay_play = (r_state == ST_PLAYING) && (w_state_nxt == ST_PLAYING);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; bad collision outranks score limit, which outranks pause
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_OVER: begin
            if (bus.start_i) w_state_nxt = ST_PLAYING;
         end
         ST_PLAYING: begin
            if (bus.bad_coll_i)      w_state_nxt = ST_OVER;
            else if (w_score_max)    w_state_nxt = ST_OVER;
            else if (bus.pause_i)    w_state_nxt = ST_PAUSED;
         end
         ST_PAUSED: begin
            if (bus.pause_i) w_state_nxt = ST_PLAYING;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Tick counter, direction commit and registered collision pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_pending <= DIR_RIGHT;
         r_dir     <= DIR_RIGHT;
         r_tick    <= 1'b0;
         r_good    <= 1'b0;
         r_bad     <= 1'b0;
         r_over    <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         r_good <= 1'b0;
         r_bad  <= 1'b0;
         r_over <= (w_state_nxt == ST_OVER);
         if (w_restart) begin
            r_cnt     <= '0;
            r_pending <= DIR_RIGHT;
            r_dir     <= DIR_RIGHT;
         end else if (r_state == ST_PLAYING) begin
            r_bad  <= bus.bad_coll_i;
            r_good <= bus.good_coll_i & ~bus.bad_coll_i;
            if (w_dir_valid) r_pending <= bus.dir_req_i;
            if (w_stay_play) begin
               if (w_wrap) begin
                  r_cnt  <= '0;
                  r_tick <= 1'b1;
                  r_dir  <= r_pending;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
         end
      end
   end

   assign bus.move_tick_o = r_tick;
   assign bus.dir_o       = r_dir;
   assign bus.good_coll_o = r_good;
   assign bus.bad_coll_o  = r_bad;
   assign bus.state_o     = r_state;
   assign bus.game_over_o = r_over;
endmodule
